// File: rtl/wb_register_file.sv
// MEM/WB writeback register file with two combinational ID read ports and a post-reset clear sweep.
// Optional same-cycle WB->ID bypass is enabled by defining REGFILE_WB_BYPASS_EN.
module wb_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inRegWrite,
  input  logic                  inMemToReg,
  input  logic [DATA_WIDTH-1:0] inReadData,
  input  logic [DATA_WIDTH-1:0] inALUResult,
  input  logic [ADDR_WIDTH-1:0] inWriteReg,
  input  logic [ADDR_WIDTH-1:0] inReadReg1,
  input  logic [ADDR_WIDTH-1:0] inReadReg2,
  output logic [DATA_WIDTH-1:0] outReadData1,
  output logic [DATA_WIDTH-1:0] outReadData2,
  output logic [DATA_WIDTH-1:0] outWBData,
  output logic                  outReady
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clrIdx;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic                    wrEn;
  logic [ADDR_WIDTH-1:0]   wrAddr;
  logic [DATA_WIDTH-1:0]   wrData;

  assign outWBData = inMemToReg ? inReadData : inALUResult;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= CLEAR;
      clrIdx   <= '0;
      outReady <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clrIdx <= clrIdx + 1'b1;
          if (&clrIdx) begin
            state    <= RUN;
            outReady <= 1'b1;
          end
        end
        RUN: ;
        default: begin
          state    <= CLEAR;
          clrIdx   <= '0;
          outReady <= 1'b0;
        end
      endcase
    end
  end

  // The array has no reset; the sweep and user writes share one write port.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = inWriteReg;
    wrData = outWBData;
    if (rst) begin
      if (state == CLEAR) begin
        wrEn   = 1'b1;
        wrAddr = clrIdx;
        wrData = '0;
      end else if (state == RUN) begin
        wrEn = inRegWrite && (inWriteReg != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) regs[wrAddr] <= wrData;
  end

  always_comb begin
    outReadData1 = '0;
    if (state == RUN && inReadReg1 != '0) begin
      outReadData1 = regs[inReadReg1];
`ifdef REGFILE_WB_BYPASS_EN
      if (inRegWrite && inWriteReg == inReadReg1) outReadData1 = outWBData;
`endif
    end
  end

  always_comb begin
    outReadData2 = '0;
    if (state == RUN && inReadReg2 != '0) begin
      outReadData2 = regs[inReadReg2];
`ifdef REGFILE_WB_BYPASS_EN
      if (inRegWrite && inWriteReg == inReadReg2) outReadData2 = outWBData;
`endif
    end
  end

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: hand sequences for sweep/reset corners,
// a vector table for the basic datapath, and randomized traffic against a behavioural model.
module tb_wb_register_file;

  localparam int NUM = 32;

  logic        clk;
  logic        rst;
  logic        inRegWrite;
  logic        inMemToReg;
  logic [31:0] inReadData;
  logic [31:0] inALUResult;
  logic [4:0]  inWriteReg;
  logic [4:0]  inReadReg1;
  logic [4:0]  inReadReg2;
  logic [31:0] outReadData1;
  logic [31:0] outReadData2;
  logic [31:0] outWBData;
  logic        outReady;

  wb_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk),
    .rst(rst),
    .inRegWrite(inRegWrite),
    .inMemToReg(inMemToReg),
    .inReadData(inReadData),
    .inALUResult(inALUResult),
    .inWriteReg(inWriteReg),
    .inReadReg1(inReadReg1),
    .inReadReg2(inReadReg2),
    .outReadData1(outReadData1),
    .outReadData2(outReadData2),
    .outWBData(outWBData),
    .outReady(outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model: register contents, readiness, and edges seen since reset release.
  logic [31:0] model [NUM];
  logic        mReady = 1'b0;
  int          mCount = 0;

  typedef struct {
    logic        we;
    logic        m2r;
    logic [31:0] rdd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ewb;
  } vec_t;

  vec_t vecs [8];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic m2r,
                               input logic [31:0] rdd, input logic [31:0] alu,
                               input logic [4:0] wr, input logic [4:0] r1, input logic [4:0] r2);
    rst         = r;
    inRegWrite  = we;
    inMemToReg  = m2r;
    inReadData  = rdd;
    inALUResult = alu;
    inWriteReg  = wr;
    inReadReg1  = r1;
    inReadReg2  = r2;
    #1;
  endtask

  function automatic logic [31:0] wbValue();
    return inMemToReg ? inReadData : inALUResult;
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] idx);
    if (!mReady || idx == 5'd0) return 32'h0;
`ifdef REGFILE_WB_BYPASS_EN
    if (inRegWrite && inWriteReg != 5'd0 && inWriteReg == idx) return wbValue();
`endif
    return model[idx];
  endfunction

  task automatic checkOutput(input string name);
    cmp({name, ".rd1"}, outReadData1, modelRead(inReadReg1));
    cmp({name, ".rd2"}, outReadData2, modelRead(inReadReg2));
    cmp({name, ".wb"}, outWBData, wbValue());
    cmp({name, ".ready"}, {31'h0, outReady}, {31'h0, mReady});
  endtask

  // One posedge; the model consumes the inputs that were stable before the edge.
  task automatic clockEdge();
    logic        r, we;
    logic [4:0]  wr;
    logic [31:0] wbv;
    r   = rst;
    we  = inRegWrite;
    wr  = inWriteReg;
    wbv = wbValue();
    @(posedge clk);
    if (!r) begin
      mReady = 1'b0;
      mCount = 0;
    end else if (!mReady) begin
      mCount++;
      if (mCount == NUM) begin
        mReady = 1'b1;
        for (int i = 0; i < NUM; i++) model[i] = 32'h0;
      end
    end else if (we && wr != 5'd0) begin
      model[wr] = wbv;
    end
    #1;
  endtask

  task automatic checkAllZero(input string name);
    for (int i = 0; i < NUM; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(NUM - 1 - i));
      cmp({name, ".rd1"}, outReadData1, 32'h0);
      cmp({name, ".rd2"}, outReadData2, 32'h0);
    end
  endtask

  initial begin
    int riseAt;
    logic [4:0] wr;

    for (int i = 0; i < NUM; i++) model[i] = 32'h0;

    vecs[0] = '{1'b1, 1'b0, 32'h0,        32'h12345678, 5'd5, 5'd0, 5'd0, 32'h0,        32'h0,        32'h12345678};
    vecs[1] = '{1'b1, 1'b1, 32'hCAFEF00D, 32'h00001111, 5'd7, 5'd5, 5'd5, 32'h12345678, 32'h12345678, 32'hCAFEF00D};
    vecs[2] = '{1'b1, 1'b0, 32'h0,        32'hFFFFFFFF, 5'd0, 5'd0, 5'd7, 32'h0,        32'hCAFEF00D, 32'hFFFFFFFF};
    vecs[3] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0,        32'h00000001, 5'd9, 5'd5, 5'd7, 32'h12345678, 32'hCAFEF00D, 32'h00000001};
`ifdef REGFILE_WB_BYPASS_EN
    vecs[5] = '{1'b1, 1'b0, 32'h0,        32'h00000002, 5'd9, 5'd9, 5'd0, 32'h00000002, 32'h0,        32'h00000002};
`else
    vecs[5] = '{1'b1, 1'b0, 32'h0,        32'h00000002, 5'd9, 5'd9, 5'd0, 32'h00000001, 32'h0,        32'h00000002};
`endif
    vecs[6] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd9, 5'd9, 32'h00000002, 32'h00000002, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 32'h00000055, 32'h0,        5'd9, 5'd0, 5'd9, 32'h0,        32'h00000002, 32'h00000055};

    // Reset for two cycles, then the sweep takes exactly 32 edges.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
    clockEdge();
    clockEdge();
    cmp("reset.ready", {31'h0, outReady}, 32'h0);
    cmp("reset.rd1", outReadData1, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
    for (int k = 1; k < NUM; k++) begin
      clockEdge();
      cmp("sweep.notready", {31'h0, outReady}, 32'h0);
    end
    clockEdge();
    cmp("sweep.ready", {31'h0, outReady}, 32'h1);

    // Fill registers with a marker so the next sweep has something to clear.
    for (int i = 1; i < NUM; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'(i), 5'(i), 5'd0);
      clockEdge();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd17, 5'd31);
    cmp("preload.rd1", outReadData1, 32'hDEADBEEF);
    cmp("preload.rd2", outReadData2, 32'hDEADBEEF);

    // Reset, sweep to clrIdx=10 while attempting writes, reset again mid-sweep.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h00000077, 5'd4, 5'd4, 5'd4);
    for (int k = 0; k < 10; k++) clockEdge();
    checkOutput("midsweep.clear");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h00000077, 5'd4, 5'd4, 5'd4);
    clockEdge();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h00000077, 5'd4, 5'd4, 5'd4);
    riseAt = -1;
    for (int k = 1; k <= 40 && riseAt < 0; k++) begin
      clockEdge();
      if (outReady) begin
        riseAt = k;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd4);
      end
    end
    cmp("midsweep.latency", 32'(riseAt), 32'd32);
    cmp("midsweep.reg4", outReadData1, 32'h0);
    checkAllZero("cleared");

    // A write on the edge that completes the sweep is dropped.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    for (int k = 1; k < NUM; k++) clockEdge();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h000000AA, 5'd3, 5'd3, 5'd3);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    cmp("sweepend.ready", {31'h0, outReady}, 32'h1);
    cmp("sweepend.reg3", outReadData1, 32'h0);

    // Table vectors: outputs checked combinationally before each edge.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(1'b1, vecs[v].we, vecs[v].m2r, vecs[v].rdd, vecs[v].alu,
                    vecs[v].wr, vecs[v].r1, vecs[v].r2);
      cmp($sformatf("vec%0d.rd1", v), outReadData1, vecs[v].e1);
      cmp($sformatf("vec%0d.rd2", v), outReadData2, vecs[v].e2);
      cmp($sformatf("vec%0d.wb", v), outWBData, vecs[v].ewb);
      clockEdge();
    end

    // Randomized traffic with occasional resets, checked against the model.
    for (int n = 0; n < 3000; n++) begin
      wr = 5'($urandom_range(0, 31));
      applyStimulus(($urandom_range(0, 299) != 0), 1'($urandom), 1'($urandom),
                    $urandom, $urandom, wr,
                    ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
      checkOutput("rand");
      clockEdge();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/wb_register_file.md
# wb_register_file

General-purpose register file for the 5-stage MIPS pipeline; the consumer at the far end of the MEM/WB register. It takes the MEM/WB outputs directly, performs the MemToReg writeback select, and commits results. It also serves the two combinational read ports used by the ID stage. After reset a sequencer sweeps zeros through every register, because the array has no per-entry reset. An optional WB→ID bypass removes the same-cycle write/read hazard.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  synchronous reset, active-low (sampled on posedge clk; 0 = reset)
- inRegWrite  input  1  writeback enable from MEM/WB
- inMemToReg  input  1  1 selects inReadData, 0 selects inALUResult
- inReadData  input  DATA_WIDTH  load data from MEM/WB
- inALUResult  input  DATA_WIDTH  ALU result from MEM/WB
- inWriteReg  input  ADDR_WIDTH  destination register index
- inReadReg1  input  ADDR_WIDTH  ID read port 1 index
- inReadReg2  input  ADDR_WIDTH  ID read port 2 index
- outReadData1  output  DATA_WIDTH  port 1 data (combinational)
- outReadData2  output  DATA_WIDTH  port 2 data (combinational)
- outWBData  output  DATA_WIDTH  selected writeback value (combinational), for EX forwarding
- outReady  output  1  1 once the clear sweep is complete; the pipeline must stall while 0

## Operation
- Writeback select: outWBData = inMemToReg ? inReadData : inALUResult, regardless of state.
- States: CLEAR and RUN. A 2-bit state register plus an ADDR_WIDTH-bit sweep counter clrIdx.
- Reset (rst=0 at a posedge):
  - state←CLEAR, clrIdx←0, outReady←0.
  - Array contents are not touched in this cycle.
- CLEAR (rst=1):
  - Each posedge writes reg[clrIdx]←0 and increments clrIdx.
  - On the posedge where clrIdx==NUM_REGS-1: state←RUN, outReady←1.
  - inRegWrite is ignored; no user write occurs.
  - Both read ports return 0.
- RUN:
  - At posedge, if inRegWrite=1 and inWriteReg≠0, then reg[inWriteReg]←outWBData.
  - Writes to register 0 are discarded.
  - Reads: outReadDataN = (inReadRegN==0) ? 0 : reg[inReadRegN], subject to the bypass described under Configuration.
- Reset mid-sweep or in RUN: returns to CLEAR with clrIdx=0 and restarts the full sweep. Registers already cleared are cleared again.
- Register 0 always reads 0 in every state.
- Both read ports may address the same register; each returns identical data.

## Timing
- Reset values (after the posedge with rst=0): outReady=0, state=CLEAR, clrIdx=0. outReadData1/2=0 while in CLEAR.
- Sweep latency: outReady rises exactly NUM_REGS (32) posedges after the first posedge with rst=1.
- Write latency: a value presented at posedge N is readable from cycle N+1 through the array path.
- Reads are asynchronous. Output follows the index inputs within the same cycle with no clock latency.
- Simultaneous events:
  - Read and write to the same non-zero index in the same cycle:
    - With bypass, the read returns the new value.
    - Without bypass, it returns the old value.
  - A write present at the posedge that completes the sweep is dropped, because state is still CLEAR at that edge.

## Configuration
- Macro REGFILE_WB_BYPASS_EN.
- Defined: in RUN, if inRegWrite=1, inWriteReg≠0 and inWriteReg==inReadRegN, then outReadDataN = outWBData in the same cycle. The hazard unit needs no WB-stage stall.
- Undefined: no bypass. Reads return array contents only, and the hazard unit must stall ID one cycle on a WB→ID dependency.
- Bypass is never applied in CLEAR or for index 0.

## Test plan
- Reset then sweep: hold rst=0 for 2 cycles, release. outReady must be 0 for 31 posedges and 1 after the 32nd. Every index reads 0 afterwards, including indices preloaded with 0xDEADBEEF via backdoor before reset.
- Write/read: in RUN, inRegWrite=1, inMemToReg=0, inALUResult=0x12345678, inWriteReg=5. Next cycle, inReadReg1=5 gives 0x12345678. inMemToReg=1 with inReadData=0xCAFEF00D to reg 7 gives 0xCAFEF00D on port 2.
- $zero: write 0xFFFFFFFF to reg 0 → both ports read 0 when inReadReg=0, with and without the macro.
- Same-cycle hazard: reg 9 holds 0x1. Write 0x2 to reg 9 while reading reg 9. With REGFILE_WB_BYPASS_EN the read gives 0x2; without it, 0x1 that cycle and 0x2 the next.
- Mid-sweep reset: assert rst=0 when clrIdx=10, release. outReady must rise 32 posedges after release, not 22. Writes attempted during CLEAR must not appear after outReady=1.
- Sweep-end edge: drive inRegWrite=1 to reg 3 (0xAA) on the posedge that sets outReady. Reg 3 must read 0 afterwards.
